// File: rtl/mmu_axi_rd_master_pkg.sv
// rtl/mmu_axi_rd_master_pkg.sv - shared AXI constants and FSM state encoding for the MMU read initiator
package mmu_axi_rd_master_pkg;

  localparam logic [7:0] ARLEN_SINGLE   = 8'd0;
  localparam logic [2:0] ARSIZE_4B      = 3'b010;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [3:0] ARCACHE_NORMAL = 4'b0011;
  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

endpackage

// File: rtl/mmu_rd_arbiter.sv
// rtl/mmu_rd_arbiter.sv - inst/data pending flags, address capture and data-first selection
module mmu_rd_arbiter
  import mmu_axi_rd_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_rden,
  input  logic [31:0] inst_raddr,
  input  logic        data_rden,
  input  logic [31:0] data_raddr,
  input  logic        grant,
  output logic        any_pend,
  output logic        sel_is_data,
  output logic [31:0] sel_addr
);

  logic        inst_pend;
  logic        data_pend;
  logic [31:0] inst_addr;
  logic [31:0] data_addr;

  assign any_pend    = inst_pend | data_pend;
  assign sel_is_data = data_pend;
  assign sel_addr    = data_pend ? data_addr : inst_addr;

  // A request is latched only when its own source is free; grant retires the selected source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_pend <= 1'b0;
      data_pend <= 1'b0;
      inst_addr <= '0;
      data_addr <= '0;
    end else begin
      if (grant && data_pend) begin
        data_pend <= 1'b0;
      end else if (data_rden && !data_pend) begin
        data_pend <= 1'b1;
        data_addr <= data_raddr;
      end
      if (grant && !data_pend) begin
        inst_pend <= 1'b0;
      end else if (inst_rden && !inst_pend) begin
        inst_pend <= 1'b1;
        inst_addr <= inst_raddr;
      end
    end
  end

endmodule

// File: rtl/mmu_axi_rd_master.sv
// rtl/mmu_axi_rd_master.sv - AXI4 single-beat read initiator for MMU fetches; RD_ERR under MMU_AXI_RD_ERR_EN
module mmu_axi_rd_master
  import mmu_axi_rd_master_pkg::*;
#(
  parameter int                        C_M_AXI_ADDR_WIDTH = 32,
  parameter int                        C_M_AXI_DATA_WIDTH = 32,
  parameter int                        C_OFFSET_WIDTH     = 32,
  parameter logic [C_OFFSET_WIDTH-1:0] C_OFFSET           = 32'h0000_0000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          INST_RDEN,
  input  logic [31:0]                   INST_RADDR,
  output logic                          INST_RVALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0] INST_RDATA,
  input  logic                          DATA_RDEN,
  input  logic [31:0]                   DATA_RADDR,
  output logic                          DATA_RVALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0] DATA_RDATA,
  output logic                          MEM_WAIT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
`ifdef MMU_AXI_RD_ERR_EN
  ,
  output logic                          RD_ERR
`endif
);

  state_t                        state_q;
  state_t                        state_d;
  logic                          grant;
  logic                          any_pend;
  logic                          sel_is_data;
  logic [31:0]                   sel_addr;
  logic                          cur_is_data;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic                          r_fire;
  logic                          inst_rvalid_q;
  logic                          data_rvalid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] inst_rdata_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] data_rdata_q;

  assign r_fire = (state_q == S_R) && M_AXI_RVALID;

  mmu_rd_arbiter u_arb (
    .clk         (CLK),
    .rst_n       (RST),
    .inst_rden   (INST_RDEN),
    .inst_raddr  (INST_RADDR),
    .data_rden   (DATA_RDEN),
    .data_raddr  (DATA_RADDR),
    .grant       (grant),
    .any_pend    (any_pend),
    .sel_is_data (sel_is_data),
    .sel_addr    (sel_addr)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, grant strobe and AXI handshake outputs
  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_pend) begin
          grant   = 1'b1;
          state_d = S_AR;
        end
      end
      S_AR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = S_R;
        end
      end
      S_R: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Freeze the offset address and source at grant so ARADDR holds while the arbiter moves on
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      araddr_q    <= '0;
      cur_is_data <= 1'b0;
    end else if (grant) begin
      araddr_q    <= C_M_AXI_ADDR_WIDTH'(C_OFFSET) + C_M_AXI_ADDR_WIDTH'(sel_addr);
      cur_is_data <= sel_is_data;
    end
  end

  // Return data to the owning source with a one-cycle valid pulse; data is held between pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      if (r_fire) begin
        if (cur_is_data) begin
          data_rvalid_q <= 1'b1;
          data_rdata_q  <= M_AXI_RDATA;
        end else begin
          inst_rvalid_q <= 1'b1;
          inst_rdata_q  <= M_AXI_RDATA;
        end
      end
    end
  end

`ifdef MMU_AXI_RD_ERR_EN
  logic rd_err_q;

  // Sticky error: any non-OKAY beat latches it until reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_err_q <= 1'b0;
    end else if (r_fire && (M_AXI_RRESP != RESP_OKAY)) begin
      rd_err_q <= 1'b1;
    end
  end

  assign RD_ERR = rd_err_q;

  logic unused_in;
  assign unused_in = M_AXI_RLAST;
`else
  logic unused_in;
  assign unused_in = ^{M_AXI_RLAST, M_AXI_RRESP};
`endif

  assign INST_RVALID   = inst_rvalid_q;
  assign DATA_RVALID   = data_rvalid_q;
  assign INST_RDATA    = inst_rdata_q;
  assign DATA_RDATA    = data_rdata_q;
  assign MEM_WAIT      = any_pend | (state_q != S_IDLE);
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = ARLEN_SINGLE;
  assign M_AXI_ARSIZE  = ARSIZE_4B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARCACHE = ARCACHE_NORMAL;
  assign M_AXI_ARPROT  = ARPROT_DEFAULT;

endmodule
